// File: rtl/pdm_stereo_decoder.sv
// Two-channel PDM-to-PCM decoder using a sliding-window ones count (boxcar).
// Optional per-channel IIR smoothing stage is enabled with `define PDM_DEC_IIR_EN.
module pdm_stereo_decoder #(
   parameter int WIN_LOG2  = 8,
   parameter int IIR_SHIFT = 4
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic        lft_PDM,
   input  logic        rght_PDM,
   output logic [15:0] lft_inverse,
   output logic [15:0] rght_inverse
);

   localparam int W  = 1 << WIN_LOG2;
   localparam int SW = WIN_LOG2 + 1;
   localparam logic [W-1:0]  HIST_INIT = {(W/2){2'b10}};
   localparam logic [SW-1:0] SUM_INIT  = SW'(W/2);

   generate
      if (WIN_LOG2 < 4 || WIN_LOG2 > 15 || IIR_SHIFT < 1 || IIR_SHIFT > 12) begin : g_bad_params
         $error("pdm_stereo_decoder: WIN_LOG2 or IIR_SHIFT out of range");
      end
   endgenerate

   logic [1:0]  w_pdm;
   logic [15:0] w_dout [2];

   assign w_pdm        = {rght_PDM, lft_PDM};
   assign lft_inverse  = w_dout[0];
   assign rght_inverse = w_dout[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         logic [W-1:0]  r_hist;
         logic [SW-1:0] r_sum;
         logic [15:0]   r_box;
         logic [16:0]   w_raw;
         logic [15:0]   w_box_next;

         // A full window (sum == W) scales to 65536 and is clamped to the top code.
         assign w_raw      = {{(16-WIN_LOG2){1'b0}}, r_sum} << (16 - WIN_LOG2);
         assign w_box_next = (w_raw[16] ? 16'hFFFF : w_raw[15:0]) ^ 16'h8000;

         always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
               r_hist <= HIST_INIT;
               r_sum  <= SUM_INIT;
               r_box  <= 16'h0000;
            end else begin
               r_hist <= {r_hist[W-2:0], w_pdm[gi]};
               r_sum  <= r_sum + {{WIN_LOG2{1'b0}}, w_pdm[gi]}
                               - {{WIN_LOG2{1'b0}}, r_hist[W-1]};
               r_box  <= w_box_next;
            end
         end

`ifdef PDM_DEC_IIR_EN
         localparam int YW = 16 + IIR_SHIFT;
         logic signed [YW-1:0] r_y;
         logic signed [YW:0]   w_diff;
         logic        [YW-1:0] w_step;

         // One guard bit keeps x - y from overflowing; the step always fits in YW.
         assign w_diff = $signed({r_box[15], r_box, {IIR_SHIFT{1'b0}}}) - $signed({r_y[YW-1], r_y});
         assign w_step = YW'(w_diff >>> IIR_SHIFT);

         always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
               r_y <= '0;
            end else begin
               r_y <= r_y + $signed(w_step);
            end
         end

         assign w_dout[gi] = r_y[YW-1 -: 16];
`else
         assign w_dout[gi] = r_box;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_pdm_stereo_decoder.sv
// Directed self-checking bench for pdm_stereo_decoder (W=256, IIR disabled).
module tb_pdm_stereo_decoder;

   logic        clk = 1'b0;
   logic        RST_n;
   logic        lft_PDM;
   logic        rght_PDM;
   logic [15:0] lft_inverse;
   logic [15:0] rght_inverse;

   int checks = 0;
   int fails  = 0;

   pdm_stereo_decoder #(.WIN_LOG2(8), .IIR_SHIFT(4)) dut (
      .clk          (clk),
      .RST_n        (RST_n),
      .lft_PDM      (lft_PDM),
      .rght_PDM     (rght_PDM),
      .lft_inverse  (lft_inverse),
      .rght_inverse (rght_inverse)
   );

   always #10 clk = ~clk;

   // Drive one bit per channel, let it be sampled, then settle past the edge.
   task automatic tick(input logic l, input logic r);
      lft_PDM  = l;
      rght_PDM = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      RST_n    = 1'b0;
      lft_PDM  = 1'b0;
      rght_PDM = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h0000) begin
            $display("FAIL reset_hold cyc=%0d got L=%h R=%h expected 0000/0000", i, lft_inverse, rght_inverse);
            fails++;
         end
      end
      RST_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(((i % 2) == 0), ((i % 2) == 0));
         checks++;
         if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h0000) begin
            $display("FAIL reset_release cyc=%0d got L=%h R=%h expected 0000/0000", i, lft_inverse, rght_inverse);
            fails++;
         end
      end
      $display("test_reset done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 256; i++) tick(1'b1, 1'b0);
      checks++;
      if (lft_inverse !== 16'h7F00) begin
         $display("FAIL sat_pre got L=%h expected 7f00", lft_inverse);
         fails++;
      end
      tick(1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (lft_inverse !== 16'h7FFF || rght_inverse !== 16'h8000) begin
            $display("FAIL saturation cyc=%0d got L=%h R=%h expected 7fff/8000", i, lft_inverse, rght_inverse);
            fails++;
         end
         tick(1'b1, 1'b0);
      end
      $display("test_saturation done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_quarter();
      for (int i = 0; i < 260; i++) tick(((i % 4) == 0), ((i % 4) == 0));
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lft_inverse !== 16'hC000 || rght_inverse !== 16'hC000) begin
            $display("FAIL quarter cyc=%0d got L=%h R=%h expected c000/c000", i, lft_inverse, rght_inverse);
            fails++;
         end
         tick(((i % 4) == 0), ((i % 4) == 0));
      end
      $display("test_quarter done: checks=%0d fails=%0d", checks, fails);
   endtask

   // Window is 0,1 alternating with a 0 oldest, so every other new 1 displaces a 0.
   task automatic test_step_latency();
      logic [15:0] exp_l;
      int c;
      for (int i = 0; i < 258; i++) tick(((i % 2) == 1), ((i % 2) == 1));
      checks++;
      if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h0000) begin
         $display("FAIL step_base got L=%h R=%h expected 0000/0000", lft_inverse, rght_inverse);
         fails++;
      end
      for (int i = 0; i < 260; i++) begin
         tick(1'b1, ((i % 2) == 1));
         c     = (i + 1) / 2;
         exp_l = (c >= 128) ? 16'h7FFF : 16'(c * 256);
         checks++;
         if (lft_inverse !== exp_l || rght_inverse !== 16'h0000) begin
            $display("FAIL step cyc=%0d got L=%h R=%h expected %h/0000", i, lft_inverse, rght_inverse, exp_l);
            fails++;
         end
      end
      $display("test_step_latency done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_midstream_reset();
      logic [15:0] exp_l;
      for (int i = 0; i < 257; i++) tick(1'b1, 1'b1);
      checks++;
      if (lft_inverse !== 16'h7FFF || rght_inverse !== 16'h7FFF) begin
         $display("FAIL midrst_pre got L=%h R=%h expected 7fff/7fff", lft_inverse, rght_inverse);
         fails++;
      end
      RST_n = 1'b0;
      #2;
      checks++;
      if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h0000) begin
         $display("FAIL midrst_async got L=%h R=%h expected 0000/0000", lft_inverse, rght_inverse);
         fails++;
      end
      #7;
      RST_n = 1'b1;
      #1;
      checks++;
      if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h0000) begin
         $display("FAIL midrst_release got L=%h R=%h expected 0000/0000", lft_inverse, rght_inverse);
         fails++;
      end
      // Left fed zeros drains the alternating window one step every other cycle.
      for (int i = 0; i < 12; i++) begin
         tick(1'b0, ((i % 2) == 0));
         exp_l = 16'(0 - (((i + 1) / 2) * 256));
         checks++;
         if (lft_inverse !== exp_l || rght_inverse !== 16'h0000) begin
            $display("FAIL midrst_window cyc=%0d got L=%h R=%h expected %h/0000", i, lft_inverse, rght_inverse, exp_l);
            fails++;
         end
      end
      $display("test_midstream_reset done: checks=%0d fails=%0d", checks, fails);
   endtask

   task automatic test_independence();
      for (int i = 0; i < 260; i++) tick(((i % 2) == 0), ((i % 4) != 3));
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (lft_inverse !== 16'h0000 || rght_inverse !== 16'h4000) begin
            $display("FAIL independence cyc=%0d got L=%h R=%h expected 0000/4000", i, lft_inverse, rght_inverse);
            fails++;
         end
         tick(((i % 2) == 0), ((i % 4) != 3));
      end
      $display("test_independence done: checks=%0d fails=%0d", checks, fails);
   endtask

   initial begin
      test_reset();
      test_saturation();
      test_quarter();
      test_step_latency();
      test_midstream_reset();
      test_independence();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
